// File: rtl/pipe_stage_vr.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and a stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry stage with a registered in_ready.
module pipe_stage_vr #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_xfer;
  logic              main_load;

  assign in_xfer   = in_valid && in_ready;
  // Main register may take new content when empty or when its payload leaves this cycle.
  assign main_load = !out_valid_q || out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // Ready comes straight from a flop, breaking the out_ready -> in_ready path.
  assign in_ready = !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        // in_ready was low, so no new payload can arrive in this cycle.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = out_ready || !out_valid_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else if (main_load) begin
      if (in_xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end
`endif

  // Saturating stall counter; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_vr.sv
// Directed and randomised checks for pipe_stage_vr; honours PIPE_STAGE_SKID_EN like the RTL.
module tb_pipe_stage_vr;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad = 0;

  pipe_stage_vr #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_init_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_init_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL rst_pre_stall got=%0d exp=2", stall_cnt); end
    // Assert reset in the low phase of the clock: no edge occurs before sampling.
    @(negedge clk);
    #1 reset = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_async_data got=%h exp=0", out_data); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_async_stall got=%0d exp=0", stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = k;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== DW'(k)) begin
        bad++; $display("FAIL stream_out k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, k);
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] items [3];
    logic [DW-1:0] got [$];
    int idx;
    logic exp_rdy;
    items[0] = 32'hA; items[1] = 32'hB; items[2] = 32'hC;
    idx = 0;
    do_reset();
    for (int cyc = 0; cyc < 13; cyc++) begin
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? items[idx] : '0;
      out_ready = (cyc >= 3);
      #1;
      if (cyc < 3) begin
        exp_rdy = (cyc == 0) ? 1'b1 : ((cyc == 1) ? SKID : 1'b0);
        total++;
        if (in_ready !== exp_rdy) begin
          bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
        end
      end
      if (cyc == 2) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
          bad++; $display("FAIL bp_hold got=%b/%h exp=1/a", out_valid, out_data);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
      tick();
    end
    total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i] !== items[i]) begin
          bad++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], items[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_data = 32'hC; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_full_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL flush_data got=%h exp=0", out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak k=%0d got=%b/%h exp=0", k, out_valid, out_data); end
    end
    // Payload accepted in the flush cycle must be dropped.
    in_valid = 1'b1; in_data = 32'hD; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_empty_ready got=%b exp=1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_prio got=%b/%h exp=0", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_prio2 got=%b/%h exp=0", out_valid, out_data); end
  endtask

  task automatic test_stall_cnt();
    int exp_cnt;
    do_reset();
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = (k > 15) ? 15 : k;
      total++;
      if (stall_cnt !== CW'(exp_cnt)) begin
        bad++; $display("FAIL stall_sat k=%0d got=%0d exp=%0d", k, stall_cnt, exp_cnt);
      end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_flush got=%0d exp=15", stall_cnt); end
    tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_flush2 got=%0d exp=15", stall_cnt); end
    do_reset();
    #1;
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL stall_reset got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q [$];
    int  stall_m;
    logic exp_rdy, acc, ov, fl, ordy;
    int  errs;
    errs = 0;
    stall_m = 0;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      ordy      = ($urandom_range(0, 2) != 0);
      fl        = ($urandom_range(0, 31) == 0);
      out_ready = ordy;
      flush     = fl;
      in_data   = $urandom;
      #1;
      exp_rdy = SKID ? (q.size() < 2) : (ordy || (q.size() == 0));
      total++;
      if (in_ready !== exp_rdy && errs < 20) begin
        errs++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, in_ready, exp_rdy);
      end
      if (in_ready !== exp_rdy) bad++;
      acc = in_valid && exp_rdy;
      ov  = (q.size() > 0);
      if (ov && !ordy && stall_m != 15) stall_m++;
      if (fl) begin
        q.delete();
      end else begin
        if (ov && ordy) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      tick();
      total++;
      if (out_valid !== (q.size() > 0)) begin
        bad++;
        if (errs < 20) begin errs++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
      end
      if (q.size() > 0) begin
        total++;
        if (out_data !== q[0]) begin
          bad++;
          if (errs < 20) begin errs++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, out_data, q[0]); end
        end
      end else if (fl) begin
        total++;
        if (out_data !== '0) begin
          bad++;
          if (errs < 20) begin errs++; $display("FAIL rnd_flush_data i=%0d got=%h exp=0", i, out_data); end
        end
      end
      total++;
      if (stall_cnt !== CW'(stall_m)) begin
        bad++;
        if (errs < 20) begin errs++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, stall_cnt, stall_m); end
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_cnt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
